// File: rtl/logic_unit_pipe_if.sv
// Handshake bus for logic_unit_pipe. It carries the operand/opcode request channel
// and the registered-result response channel. The master drives requests; the slave is the unit.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;
   logic             parity;
   logic             illegal;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, zero, parity, illegal, op_count
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, zero, parity, illegal, op_count
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Single-stage bitwise logic unit with a valid/ready handshake on both sides.
// Each bit lane is evaluated independently and captured into one result register.
module logic_unit_lane (
   input  logic [2:0] op,
   input  logic       a,
   input  logic       b,
   output logic       y
);
   always_comb begin
      y = 1'b0;
      case (op)
         3'd0:    y = a | b;
         3'd1:    y = a & b;
         3'd2:    y = ~a;
         3'd3:    y = a ^ b;
         3'd4:    y = ~(a ^ b);
         3'd5:    y = ~(a & b);
         3'd6:    y = ~(a | b);
         default: y = 1'b0;  // op 7 is illegal and yields zero
      endcase
   end
endmodule

module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   logic_unit_pipe_if.slave bus
);
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] y_q;
   logic             vld_q;
   logic             ill_q;
   logic [CNT_W-1:0] cnt_q;
   logic             xfer_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic_unit_lane u_lane (
         .op (bus.op),
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .y  (res_d[i])
      );
   end

   // A held result frees the slot in the same cycle it is taken downstream.
   assign bus.in_ready = !vld_q || bus.out_ready;
   assign xfer_in      = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= 1'b0;
         y_q   <= '0;
         ill_q <= 1'b0;
         cnt_q <= '0;
      end else if (xfer_in) begin
         vld_q <= 1'b1;
         y_q   <= res_d;
         ill_q <= (bus.op == 3'd7);
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (bus.out_ready) begin
         vld_q <= 1'b0;
      end
   end

   // Flags are pure functions of the result register, so they never see a/b/op directly.
   assign bus.out_valid = vld_q;
   assign bus.y         = y_q;
   assign bus.zero      = ~|y_q;
   assign bus.parity    = ^y_q;
   assign bus.illegal   = ill_q;
   assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Drives WIDTH=8/CNT_W=16, WIDTH=1/CNT_W=4 and WIDTH=64/CNT_W=4 units in lockstep from one stimulus stream.
// Each unit is compared against a transaction-level reference model.
module tb_logic_unit_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [2:0]  op;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_ok  = 1'b0;
   bit          m_vld;
   logic [63:0] m_y;
   bit          m_ill;
   int unsigned m_cnt;

   logic [7:0] exp32 [7] = '{8'hFF, 8'h00, 8'h3A, 8'hFF, 8'h00, 8'hFF, 8'h00};

   always #5 clk = ~clk;

   logic_unit_pipe_if #(.WIDTH(8),  .CNT_W(16)) if8  ();
   logic_unit_pipe_if #(.WIDTH(1),  .CNT_W(4))  if1  ();
   logic_unit_pipe_if #(.WIDTH(64), .CNT_W(4))  if64 ();

   assign if8.in_valid   = in_valid;
   assign if8.out_ready  = out_ready;
   assign if8.a          = a[7:0];
   assign if8.b          = b[7:0];
   assign if8.op         = op;
   assign if1.in_valid   = in_valid;
   assign if1.out_ready  = out_ready;
   assign if1.a          = a[0:0];
   assign if1.b          = b[0:0];
   assign if1.op         = op;
   assign if64.in_valid  = in_valid;
   assign if64.out_ready = out_ready;
   assign if64.a         = a;
   assign if64.b         = b;
   assign if64.op        = op;

   logic_unit_pipe #(.WIDTH(8),  .CNT_W(16)) u8  (.clk(clk), .rst(rst), .bus(if8.slave));
   logic_unit_pipe #(.WIDTH(1),  .CNT_W(4))  u1  (.clk(clk), .rst(rst), .bus(if1.slave));
   logic_unit_pipe #(.WIDTH(64), .CNT_W(4))  u64 (.clk(clk), .rst(rst), .bus(if64.slave));

   function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] z);
      case (o)
         3'd0:    return x | z;
         3'd1:    return x & z;
         3'd2:    return ~x;
         3'd3:    return x ^ z;
         3'd4:    return ~(x ^ z);
         3'd5:    return ~(x & z);
         3'd6:    return ~(x | z);
         default: return 64'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out();
      chk("u8.out_valid",  64'(if8.out_valid),  64'(m_vld));
      chk("u8.y",          64'(if8.y),          64'(m_y[7:0]));
      chk("u8.zero",       64'(if8.zero),       64'(m_y[7:0] == 8'd0));
      chk("u8.parity",     64'(if8.parity),     64'(^m_y[7:0]));
      chk("u8.illegal",    64'(if8.illegal),    64'(m_ill));
      chk("u8.op_count",   64'(if8.op_count),   64'(m_cnt % 65536));
      chk("u1.out_valid",  64'(if1.out_valid),  64'(m_vld));
      chk("u1.y",          64'(if1.y),          64'(m_y[0]));
      chk("u1.zero",       64'(if1.zero),       64'(!m_y[0]));
      chk("u1.parity",     64'(if1.parity),     64'(m_y[0]));
      chk("u1.illegal",    64'(if1.illegal),    64'(m_ill));
      chk("u1.op_count",   64'(if1.op_count),   64'(m_cnt % 16));
      chk("u64.out_valid", 64'(if64.out_valid), 64'(m_vld));
      chk("u64.y",         if64.y,              m_y);
      chk("u64.zero",      64'(if64.zero),      64'(m_y == 64'd0));
      chk("u64.parity",    64'(if64.parity),    64'(^m_y));
      chk("u64.illegal",   64'(if64.illegal),   64'(m_ill));
      chk("u64.op_count",  64'(if64.op_count),  64'(m_cnt % 16));
   endtask

   // One clock: check in_ready before the edge, advance the model on the edge, check outputs after.
   task automatic step();
      bit rdy;
      #1;
      if (m_ok) begin
         rdy = !m_vld || out_ready;
         chk("u8.in_ready",  64'(if8.in_ready),  64'(rdy));
         chk("u1.in_ready",  64'(if1.in_ready),  64'(rdy));
         chk("u64.in_ready", 64'(if64.in_ready), 64'(rdy));
      end
      @(posedge clk);
      if (rst) begin
         m_vld = 1'b0; m_y = '0; m_ill = 1'b0; m_cnt = 0; m_ok = 1'b1;
      end else if (in_valid && (!m_vld || out_ready)) begin
         m_y = ref_op(op, a, b); m_ill = (op == 3'd7); m_vld = 1'b1; m_cnt++;
      end else if (out_ready) begin
         m_vld = 1'b0;
      end
      #1;
      if (m_ok) check_out();
   endtask

   initial begin
      // reset with a coincident request that must be dropped
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = '1; b = '0; op = 3'd0;
      step(); step();
      rst = 1'b0; in_valid = 1'b0;
      step();
      chk("rst.op_count", 64'(if8.op_count), 64'd0);
      chk("rst.zero",     64'(if8.zero),     64'd1);

      // every legal op on a fixed operand pair at full throughput
      a = 64'hC5; b = 64'h3A; in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         op = 3'(i);
         step();
         chk("ops.y", 64'(if8.y), 64'(exp32[i]));
      end
      in_valid = 1'b0;
      step();
      chk("ops.op_count", 64'(if8.op_count), 64'd7);

      // stall holds the result and blocks input
      in_valid = 1'b1; a = 64'hF0; b = 64'h0F; op = 3'd3;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 6));
         step();
         chk("stall.y",        64'(if8.y),        64'hFF);
         chk("stall.in_ready", 64'(if8.in_ready), 64'd0);
         chk("stall.op_count", 64'(if8.op_count), 64'd8);
      end
      out_ready = 1'b1; a = 64'h12; b = 64'h34; op = 3'd0;
      step();
      chk("unstall.out_valid", 64'(if8.out_valid), 64'd1);
      chk("unstall.y",         64'(if8.y),         64'h36);

      // illegal opcode still transfers and counts
      a = '1; b = '1; op = 3'd7;
      step();
      chk("ill.y",       64'(if8.y),        64'h00);
      chk("ill.illegal", 64'(if8.illegal),  64'd1);
      chk("ill.zero",    64'(if8.zero),     64'd1);
      chk("ill.parity",  64'(if8.parity),   64'd0);
      chk("ill.count",   64'(if8.op_count), 64'd10);

      // reset in the middle of a stall
      op = 3'd1; a = 64'hFF; b = 64'h0F; out_ready = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("rststall.out_valid", 64'(if8.out_valid), 64'd0);
      chk("rststall.y",         64'(if8.y),         64'd0);
      chk("rststall.op_count",  64'(if8.op_count),  64'd0);
      chk("rststall.in_ready",  64'(if8.in_ready),  64'd1);
      in_valid = 1'b1;
      step();
      chk("rststall.accept", 64'(if8.out_valid), 64'd1);

      // counter wrap on the CNT_W=4 units
      rst = 1'b1; out_ready = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
         step();
      end
      chk("wrap.u1",  64'(if1.op_count),  64'd1);
      chk("wrap.u64", 64'(if64.op_count), 64'd1);
      chk("wrap.u8",  64'(if8.op_count),  64'd17);

      // exhaustive single-bit operand combinations for every op
      for (int o = 0; o < 8; o++)
         for (int ab = 0; ab < 4; ab++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            a[0] = ab[0]; b[0] = ab[1]; op = 3'(o);
            step();
         end

      // random handshake traffic with rare resets
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, sets operand and result width in bits (legal 1..64).
REQ-002 Parameter CNT_W, default 16, sets the completed-operation counter width.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode on a, b, op is valid this cycle.
REQ-006 in_ready  output  1  block accepts a transfer this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  operation select, encoded per REQ-014.
REQ-010 out_valid  output  1  y and flags hold a valid result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 y  output  WIDTH  registered result.
REQ-013 zero, parity, illegal, op_count  output  1,1,1,CNT_W  result==0; XOR-reduce of y; op was 7; accepted-transfer count.

Function
REQ-014 op encoding, bitwise over WIDTH: 0 OR; 1 AND; 2 NOT a (b ignored); 3 XOR; 4 XNOR; 5 NAND; 6 NOR; 7 illegal, result all-zero.
REQ-015 Input transfer occurs when in_valid && in_ready on a rising clk edge.
REQ-016 Output transfer occurs when out_valid && out_ready on a rising clk edge.
REQ-017 Result register is a single stage; latency from input transfer to out_valid high is exactly 1 cycle.
REQ-018 in_ready = !out_valid || out_ready (combinational); full throughput of one result per cycle while out_ready stays high.
REQ-019 On input transfer, y, zero, parity and illegal load from the current a, b, op and out_valid is set to 1.
REQ-020 On output transfer with no simultaneous input transfer, out_valid clears to 0; y and flags hold their last values.
REQ-021 On simultaneous output and input transfer, new result loads and out_valid stays 1 (no bubble).
REQ-022 While out_valid=1 and out_ready=0, y, flags and out_valid hold stable; in_ready=0; a/b/op are ignored.
REQ-023 in_valid=0 with out_valid=0: registers hold, out_valid stays 0.
REQ-024 zero=1 iff the registered y is all-zero, including for op 7.
REQ-025 parity equals XOR-reduce of the registered y.
REQ-026 illegal=1 iff the registered op was 7; op 7 is still a normal transfer and increments op_count.
REQ-027 op_count increments by 1 on every input transfer, wraps from 2^CNT_W-1 to 0 without saturation or flag.
REQ-028 Output values depend only on registered state; no combinational path from a, b or op to any output.

Reset
REQ-029 While rst=1 at a clk edge: out_valid=0, y=0, zero=1, parity=0, illegal=0, op_count=0.
REQ-030 in_ready is 1 during and after reset (out_valid=0); an in_valid coincident with rst=1 is dropped and not counted.
REQ-031 Reset asserted mid-stall discards the held result; first cycle after rst deasserts accepts a new transfer.

Verification
REQ-032 WIDTH=8, ops 0..6 with a=8'hC5, b=8'h3A, out_ready=1 -> one cycle later y = FF,00,3A,FF,00,FF,00 respectively; zero=1 on 00 results; op_count=7 after the seventh transfer.
REQ-033 Stall: transfer a=8'hF0,b=8'h0F,op=3, then out_ready=0 for 4 cycles with new in_valid -> y=8'hFF held, in_ready=0, op_count unchanged; on out_ready=1 new input accepted same cycle, out_valid stays 1.
REQ-034 op=7, a=b=8'hFF -> y=8'h00, zero=1, illegal=1, parity=0, op_count increments.
REQ-035 CNT_W=4, 17 back-to-back transfers -> op_count sequence wraps 15->0, final value 1.
REQ-036 rst pulsed while out_valid=1, out_ready=0 -> next cycle out_valid=0, y=0, op_count=0, in_ready=1.
REQ-037 WIDTH=1 and WIDTH=64 exhaustive/random ops against a bitwise model -> y, zero, parity match every transfer.
